// File: rtl/noc_ni_inject.sv
// Local-port injection stage: per-VC flit FIFOs, round-robin VC arbitration toward the
// router input port, and per-VC outstanding (un-acked) flit accounting.
module noc_ni_inject #(
  parameter int unsigned FLIT_W  = 35,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [FLIT_W-1:0] CDATA,
  input  logic              CVALID,
  input  logic              CVCH,
  output logic              CRDY,
  output logic [FLIT_W-1:0] ODATA,
  output logic              OVALID,
  output logic              OVCH,
  input  logic [1:0]        IRDY,
  input  logic [1:0]        IACK,
  input  logic [1:0]        ILCK,
  output logic [7:0]        OUTST,
  output logic              ERR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam int unsigned HB = FLIT_W - 2;

  logic [1:0]        full;
  logic [1:0]        empty;
  logic [1:0]        elig;
  logic [1:0]        send;
  logic [1:0]        err_hit;
  logic [FLIT_W-1:0] front [2];
  logic              push;
  logic              gnt_valid;
  logic              gnt_vc;
  logic              rr_ptr;

  assign CRDY = RST_ && !full[CVCH];
  assign push = CVALID && CRDY;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [CW-1:0]     cnt;
    logic              wr_en;

    assign wr_en = push && (CVCH == 1'(v));

    // Storage carries no reset; validity is defined purely by the pointers.
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= CDATA;
    end

    always_ff @(posedge clk or negedge RST_) begin
      if (!RST_) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en)   wr_ptr <= wr_ptr + (AW+1)'(1);
        if (send[v]) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (send[v] && !IACK[v])
          cnt <= cnt + CW'(1);
        else if (!send[v] && IACK[v] && (cnt != '0))
          cnt <= cnt - CW'(1);
      end
    end

    assign empty[v]   = (wr_ptr == rd_ptr);
    assign full[v]    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign front[v]   = mem[rd_ptr[AW-1:0]];
    // Lock only blocks a new packet start; body/tail of an open packet always proceed.
    assign elig[v]    = !empty[v] && IRDY[v] && (cnt < CW'(MAX_OUT)) &&
                        !(front[v][HB] && ILCK[v]);
    assign err_hit[v] = IACK[v] && (cnt == '0);
    assign OUTST[v*CW +: CW] = cnt;
  end

  // Round-robin only matters when both VCs compete; a lone requester always wins.
  always_comb begin
    gnt_valid = |elig;
    gnt_vc    = elig[1];
    if (&elig) gnt_vc = rr_ptr;
  end

  assign send[0] = gnt_valid && !gnt_vc;
  assign send[1] = gnt_valid && gnt_vc;

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      rr_ptr <= 1'b0;
      ODATA  <= '0;
      OVALID <= 1'b0;
      OVCH   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      OVALID <= gnt_valid;
      if (gnt_valid) begin
        ODATA  <= front[gnt_vc];
        OVCH   <= gnt_vc;
        rr_ptr <= !gnt_vc;
      end
      if (|err_hit) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_ni_inject.sv
// Scoreboard bench for noc_ni_inject: expected flits are queued per VC on acceptance and
// compared in order when the DUT presents them, plus directed checks on reset/lock/acks.
module tb_noc_ni_inject;

  localparam int unsigned FW = 35;

  logic          clk = 1'b0;
  logic          RST_;
  logic [FW-1:0] CDATA;
  logic          CVALID;
  logic          CVCH;
  logic          CRDY;
  logic [FW-1:0] ODATA;
  logic          OVALID;
  logic          OVCH;
  logic [1:0]    IRDY;
  logic [1:0]    IACK;
  logic [1:0]    ILCK;
  logic [7:0]    OUTST;
  logic          ERR;

  logic [1:0]    man_ack;
  logic [1:0]    ack_q1;
  logic [1:0]    ack_q2;
  logic          ack_en;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int sent_cnt = 0;

  logic [FW-1:0] exp_q0 [$];
  logic [FW-1:0] exp_q1 [$];
  int            push_edge_q [$];
  int            send_edge_q [$];
  logic          ovch_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign IACK = man_ack | (ack_en ? ack_q2 : 2'b00);

  noc_ni_inject dut (
    .clk    (clk),
    .RST_   (RST_),
    .CDATA  (CDATA),
    .CVALID (CVALID),
    .CVCH   (CVCH),
    .CRDY   (CRDY),
    .ODATA  (ODATA),
    .OVALID (OVALID),
    .OVCH   (OVCH),
    .IRDY   (IRDY),
    .IACK   (IACK),
    .ILCK   (ILCK),
    .OUTST  (OUTST),
    .ERR    (ERR)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [15:0] p);
    return {t, 17'd0, p};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_flit(input logic vc, input logic [FW-1:0] d);
    int w;
    w = 0;
    CVALID = 1'b1;
    CVCH   = vc;
    CDATA  = d;
    @(negedge clk);
    while (!CRDY && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!CRDY) check("push_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    CVALID = 1'b0;
  endtask

  task automatic do_reset();
    RST_    = 1'b0;
    CVALID  = 1'b0;
    man_ack = 2'b00;
    tick(2);
    RST_ = 1'b1;
    tick(1);
  endtask

  // Scoreboard: record accepted flits, compare every presented flit against its VC queue.
  initial forever begin
    @(negedge clk);
    if (!RST_) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (CVALID && CRDY) begin
        if (CVCH) exp_q1.push_back(CDATA);
        else      exp_q0.push_back(CDATA);
        push_edge_q.push_back(cyc + 1);
      end
      if (OVALID) begin
        sent_cnt++;
        send_edge_q.push_back(cyc);
        ovch_q.push_back(OVCH);
        if (OVCH) begin
          if (exp_q1.size() == 0) check("sb_unexpected_vc1", 64'(ODATA), 64'(0));
          else check("sb_vc1_data", 64'(ODATA), 64'(exp_q1.pop_front()));
        end else begin
          if (exp_q0.size() == 0) check("sb_unexpected_vc0", 64'(ODATA), 64'(0));
          else check("sb_vc0_data", 64'(ODATA), 64'(exp_q0.pop_front()));
        end
      end
    end
  end

  // Router ack model: echo each delivered flit two cycles later when enabled.
  initial begin
    ack_q1 = 2'b00;
    ack_q2 = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!RST_) begin
        ack_q1 = 2'b00;
        ack_q2 = 2'b00;
      end else begin
        ack_q2 = ack_q1;
        ack_q1 = OVALID ? (OVCH ? 2'b10 : 2'b01) : 2'b00;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_ = 1'b0; CDATA = '0; CVALID = 1'b0; CVCH = 1'b0;
    IRDY = 2'b00; ILCK = 2'b00; man_ack = 2'b00; ack_en = 1'b0;
    tick(2);
    check("rst_ovalid", 64'(OVALID), 64'(0));
    check("rst_crdy",   64'(CRDY),   64'(0));
    check("rst_outst",  64'(OUTST),  64'(0));
    check("rst_err",    64'(ERR),    64'(0));
    check("rst_odata",  64'(ODATA),  64'(0));
    RST_ = 1'b1;
    tick(1);
    check("rst_rel_crdy", 64'(CRDY), 64'(1));

    // T1: reset mid-stream discards buffered flits
    for (int i = 0; i < 4; i++) push_flit(1'b0, mk(2'b11, 16'(16'h10 + i)));
    IRDY = 2'b01;
    tick(1);
    check("t1_ovalid_pre", 64'(OVALID), 64'(1));
    RST_ = 1'b0;
    #1;
    check("t1_ovalid_rst", 64'(OVALID), 64'(0));
    check("t1_crdy_rst",   64'(CRDY),   64'(0));
    tick(2);
    RST_ = 1'b1;
    IRDY = 2'b11;
    sent_cnt = 0;
    tick(6);
    check("t1_no_sends", 64'(sent_cnt), 64'(0));
    check("t1_crdy",     64'(CRDY),     64'(1));
    check("t1_outst",    64'(OUTST),    64'(0));

    // T2: single packet on VC0 with echoed acks
    ack_en = 1'b1;
    push_edge_q.delete();
    send_edge_q.delete();
    sent_cnt = 0;
    push_flit(1'b0, mk(2'b01, 16'h0001));
    push_flit(1'b0, mk(2'b00, 16'h0002));
    push_flit(1'b0, mk(2'b10, 16'h0003));
    tick(6);
    check("t2_sent", 64'(sent_cnt), 64'(3));
    if (send_edge_q.size() == 3 && push_edge_q.size() == 3) begin
      check("t2_latency", 64'(send_edge_q[0] - push_edge_q[0]), 64'(1));
      check("t2_back2back_1", 64'(send_edge_q[1] - send_edge_q[0]), 64'(1));
      check("t2_back2back_2", 64'(send_edge_q[2] - send_edge_q[1]), 64'(1));
    end else begin
      check("t2_edge_count", 64'(send_edge_q.size()), 64'(3));
    end
    check("t2_outst_drained", 64'(OUTST), 64'(0));
    check("t2_err", 64'(ERR), 64'(0));

    // T3: round-robin interleave and MAX_OUT cap
    ack_en = 1'b0;
    IRDY = 2'b00;
    do_reset();
    for (int i = 0; i < 4; i++) push_flit(1'b0, mk(2'b11, 16'(16'h100 + i)));
    for (int i = 0; i < 4; i++) push_flit(1'b1, mk(2'b11, 16'(16'h200 + i)));
    ovch_q.delete();
    sent_cnt = 0;
    IRDY = 2'b11;
    tick(12);
    check("t3_sent", 64'(sent_cnt), 64'(8));
    check("t3_outst_full", 64'(OUTST), 64'(8'h44));
    if (ovch_q.size() == 8) begin
      for (int i = 0; i < 8; i++) check("t3_ovch_seq", 64'(ovch_q[i]), 64'(i % 2));
    end else begin
      check("t3_ovch_count", 64'(ovch_q.size()), 64'(8));
    end
    push_flit(1'b0, mk(2'b11, 16'h0300));
    tick(4);
    check("t3_capped", 64'(sent_cnt), 64'(8));
    man_ack = 2'b01;
    tick(1);
    man_ack = 2'b00;
    tick(3);
    check("t3_after_ack", 64'(sent_cnt), 64'(9));
    check("t3_outst_after", 64'(OUTST), 64'(8'h44));

    // T4: lock blocks a head but not body/tail of an open packet
    do_reset();
    ack_en = 1'b1;
    IRDY = 2'b11;
    ILCK = 2'b01;
    sent_cnt = 0;
    push_flit(1'b0, mk(2'b01, 16'h0400));
    push_flit(1'b1, mk(2'b11, 16'h0401));
    push_flit(1'b1, mk(2'b11, 16'h0402));
    push_flit(1'b1, mk(2'b11, 16'h0403));
    tick(4);
    check("t4_vc1_flows", 64'(sent_cnt), 64'(3));
    check("t4_vc0_held", 64'(exp_q0.size()), 64'(1));
    ILCK = 2'b00;
    tick(3);
    check("t4_head_released", 64'(sent_cnt), 64'(4));
    push_flit(1'b0, mk(2'b01, 16'h0500));
    tick(3);
    ILCK = 2'b01;
    push_flit(1'b0, mk(2'b00, 16'h0501));
    push_flit(1'b0, mk(2'b10, 16'h0502));
    tick(4);
    check("t4_body_tail_pass", 64'(sent_cnt), 64'(7));
    push_flit(1'b0, mk(2'b01, 16'h0600));
    tick(4);
    check("t4_new_head_held", 64'(sent_cnt), 64'(7));
    ILCK = 2'b00;
    tick(4);
    check("t4_new_head_sent", 64'(sent_cnt), 64'(8));

    // T5: backpressure fills VC1, full blocks the fifth flit
    do_reset();
    ack_en = 1'b1;
    IRDY = 2'b01;
    sent_cnt = 0;
    for (int i = 0; i < 4; i++) push_flit(1'b1, mk(2'b11, 16'(16'h700 + i)));
    CVALID = 1'b1;
    CVCH   = 1'b1;
    CDATA  = mk(2'b11, 16'h0704);
    tick(2);
    check("t5_crdy_full", 64'(CRDY), 64'(0));
    CVALID = 1'b0;
    CVCH   = 1'b0;
    #1;
    check("t5_crdy_vc0", 64'(CRDY), 64'(1));
    CVCH = 1'b1;
    #1;
    check("t5_crdy_vc1", 64'(CRDY), 64'(0));
    IRDY = 2'b11;
    tick(1);
    check("t5_crdy_after_pop", 64'(CRDY), 64'(1));
    tick(6);
    check("t5_sent", 64'(sent_cnt), 64'(4));
    check("t5_vc1_drained", 64'(exp_q1.size()), 64'(0));

    // T6: simultaneous send+ack, then spurious ack sets sticky ERR
    do_reset();
    ack_en = 1'b0;
    IRDY = 2'b11;
    push_flit(1'b0, mk(2'b11, 16'h0800));
    tick(3);
    check("t6_outst_one", 64'(OUTST), 64'(8'h01));
    push_flit(1'b0, mk(2'b11, 16'h0801));
    man_ack = 2'b01;
    tick(1);
    man_ack = 2'b00;
    check("t6_sent_with_ack", 64'(OVALID), 64'(1));
    check("t6_outst_same", 64'(OUTST), 64'(8'h01));
    check("t6_err_clear", 64'(ERR), 64'(0));
    man_ack = 2'b10;
    tick(1);
    man_ack = 2'b00;
    check("t6_err_set", 64'(ERR), 64'(1));
    check("t6_outst_spurious", 64'(OUTST), 64'(8'h01));
    tick(3);
    check("t6_err_sticky", 64'(ERR), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
